// File: rtl/xst_queue.sv
// xst_queue: host-side sequencer that feeds 64-bit words to the xst shift engine and returns captured results.
// Latency: a TX push in cycle n can load in cycle n+2; a result is visible on rx_valid_o the cycle after CAPTURE.
// Backpressure: tx_ready_o drops while the TX queue is full; no load starts unless RX has room for the result.

// Generic circular FIFO: power-of-two depth, pointers plus occupancy count.
// Latency: a pushed word is at the head one cycle after the push; dat_o is the combinational head.
// Backpressure: a push while full and a pop while empty are ignored; the caller gates them with cnt_o.
module xst_fifo #(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int LOG2DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 push_i,
    input  logic [W-1:0]         dat_i,
    input  logic                 pop_i,
    output logic [W-1:0]         dat_o,
    output logic [LOG2DEPTH:0]   cnt_o
);
    localparam logic [LOG2DEPTH:0] FULL_CNT = DEPTH[LOG2DEPTH:0];

    logic [W-1:0]           mem_q [DEPTH];
    logic [LOG2DEPTH-1:0]   wptr_q, rptr_q;
    logic [LOG2DEPTH:0]     cnt_q;
    logic                   do_push, do_pop;

    assign do_push = push_i && (cnt_q != FULL_CNT);
    assign do_pop  = pop_i && (cnt_q != '0);
    assign dat_o   = mem_q[rptr_q];
    assign cnt_o   = cnt_q;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array; contents are only observed through a valid head, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= dat_i;
    end
endmodule

module xst_queue #(
    parameter int DEPTH     = 4,
    parameter int LOG2DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [63:0]          tx_dat_i,
    input  logic [5:0]           tx_bits_i,
    input  logic                 tx_rev_i,
    output logic [LOG2DEPTH:0]   tx_level_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [63:0]          rx_dat_o,
    output logic [5:0]           rx_bits_o,
    output logic                 xst_we_o,
    output logic                 xst_wer_o,
    output logic                 xst_oe_o,
    output logic                 xst_oer_o,
    output logic [63:0]          xst_dat_o,
    output logic [5:0]           xst_bits_o,
    input  logic                 xst_idle_i,
    input  logic [63:0]          xst_dat_i
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_CAPTURE} state_t;

    typedef struct packed {
        logic        rev;
        logic [5:0]  bits;
        logic [63:0] dat;
    } tx_ent_t;

    typedef struct packed {
        logic [5:0]  bits;
        logic [63:0] dat;
    } rx_ent_t;

    localparam logic [LOG2DEPTH:0]   FULL_CNT = DEPTH[LOG2DEPTH:0];
    localparam logic [LOG2DEPTH+1:0] DEPTH_W  = DEPTH[LOG2DEPTH+1:0];

    state_t               state_q, state_d;
    logic                 cur_rev_q, cur_rev_d;
    logic [5:0]           cur_bits_q, cur_bits_d;
    logic                 busy_first_q, busy_first_d;

    tx_ent_t              tx_in, tx_head;
    rx_ent_t              rx_in, rx_head;
    logic [LOG2DEPTH:0]   tx_cnt, rx_cnt;
    logic                 tx_push, tx_pop, rx_push, rx_pop;
    logic                 inflight;
    logic [LOG2DEPTH+1:0] rx_used;
    logic                 rx_room;

    assign tx_in      = '{rev: tx_rev_i, bits: tx_bits_i, dat: tx_dat_i};
    assign tx_ready_o = (tx_cnt != FULL_CNT);
    assign tx_push    = tx_valid_i && tx_ready_o;
    assign tx_pop     = (state_q == S_LOAD);
    assign tx_level_o = tx_cnt;

    xst_fifo #(.W($bits(tx_ent_t)), .DEPTH(DEPTH), .LOG2DEPTH(LOG2DEPTH)) u_tx_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (tx_push),
        .dat_i    (tx_in),
        .pop_i    (tx_pop),
        .dat_o    (tx_head),
        .cnt_o    (tx_cnt)
    );

    assign rx_in      = '{bits: cur_bits_q, dat: xst_dat_i};
    assign rx_push    = (state_q == S_CAPTURE);
    assign rx_valid_o = (rx_cnt != '0);
    assign rx_pop     = rx_valid_o && rx_ready_i;
    assign rx_dat_o   = rx_valid_o ? rx_head.dat  : 64'd0;
    assign rx_bits_o  = rx_valid_o ? rx_head.bits : 6'd0;

    xst_fifo #(.W($bits(rx_ent_t)), .DEPTH(DEPTH), .LOG2DEPTH(LOG2DEPTH)) u_rx_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (rx_push),
        .dat_i    (rx_in),
        .pop_i    (rx_pop),
        .dat_o    (rx_head),
        .cnt_o    (rx_cnt)
    );

    // A transfer holds an RX slot from LOAD until its CAPTURE push lands in rx_cnt,
    // so the capture can never find RX full.
    assign inflight = (state_q != S_IDLE);
    assign rx_used  = {1'b0, rx_cnt} + {{(LOG2DEPTH+1){1'b0}}, inflight};
    assign rx_room  = (rx_used < DEPTH_W);

    // Strobes decode only registered state, so each is a clean single-cycle pulse.
    assign xst_we_o   = (state_q == S_LOAD)    && !cur_rev_q;
    assign xst_wer_o  = (state_q == S_LOAD)    &&  cur_rev_q;
    assign xst_oe_o   = (state_q == S_CAPTURE) && !cur_rev_q;
    assign xst_oer_o  = (state_q == S_CAPTURE) &&  cur_rev_q;
    assign xst_dat_o  = (state_q == S_LOAD) ? tx_head.dat  : 64'd0;
    assign xst_bits_o = (state_q == S_LOAD) ? tx_head.bits : 6'd0;

    // State and per-transfer context registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            cur_rev_q    <= 1'b0;
            cur_bits_q   <= 6'd0;
            busy_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_rev_q    <= cur_rev_d;
            cur_bits_q   <= cur_bits_d;
            busy_first_q <= busy_first_d;
        end
    end

    // Next-state logic. The head's rev/bits are latched on entry to LOAD (the head
    // cannot change before its own pop), so the LOAD strobe already decodes the right rev.
    always_comb begin
        state_d      = state_q;
        cur_rev_d    = cur_rev_q;
        cur_bits_d   = cur_bits_q;
        busy_first_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((tx_cnt != '0) && xst_idle_i && rx_room) begin
                    state_d    = S_LOAD;
                    cur_rev_d  = tx_head.rev;
                    cur_bits_d = tx_head.bits;
                end
            end
            S_LOAD: begin
                state_d      = S_BUSY;
                busy_first_d = 1'b1;
            end
            S_BUSY: begin
                // xst's idle flag still reads 1 in the cycle right after the load.
                if (!busy_first_q && xst_idle_i) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_xst_queue.sv
// Directed bench for xst_queue with a behavioural xst model.
// Model: idle drops one cycle after a load with bits!=0 and rises 80 cycles later.
// Model read data: the loaded word when bits=0, its complement otherwise.
module tb_xst_queue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] tx_dat;
    logic [5:0]  tx_bits;
    logic        tx_rev;
    logic [2:0]  tx_level;
    logic        rx_valid;
    logic        rx_ready;
    logic [63:0] rx_dat;
    logic [5:0]  rx_bits;
    logic        xst_we, xst_wer, xst_oe, xst_oer;
    logic [63:0] xst_dat_o;
    logic [5:0]  xst_bits_o;
    logic        xst_idle;
    logic [63:0] xst_dat_i;

    always #5 clk = ~clk;

    xst_queue #(.DEPTH(4), .LOG2DEPTH(2)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .tx_dat_i   (tx_dat),
        .tx_bits_i  (tx_bits),
        .tx_rev_i   (tx_rev),
        .tx_level_o (tx_level),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .rx_dat_o   (rx_dat),
        .rx_bits_o  (rx_bits),
        .xst_we_o   (xst_we),
        .xst_wer_o  (xst_wer),
        .xst_oe_o   (xst_oe),
        .xst_oer_o  (xst_oer),
        .xst_dat_o  (xst_dat_o),
        .xst_bits_o (xst_bits_o),
        .xst_idle_i (xst_idle),
        .xst_dat_i  (xst_dat_i)
    );

    // xst model
    logic [63:0] m_word = 64'd0;
    logic [5:0]  m_bits = 6'd0;
    logic        m_pend = 1'b0;
    logic        m_idle = 1'b1;
    int          m_cnt  = 0;
    logic        hold_busy = 1'b0;

    assign xst_idle  = m_idle && !hold_busy;
    assign xst_dat_i = (m_bits == 6'd0) ? m_word : ~m_word;

    int n_we = 0, n_wer = 0, n_oe = 0, n_oer = 0;
    logic [63:0] load_log[$];
    logic [63:0] rx_log[$];

    always @(posedge clk) begin
        if (xst_we || xst_wer) begin
            m_word <= xst_dat_o;
            m_bits <= xst_bits_o;
            m_pend <= 1'b1;
            load_log.push_back(xst_dat_o);
        end else if (m_pend) begin
            m_pend <= 1'b0;
            if (m_bits != 6'd0) begin
                m_idle <= 1'b0;
                m_cnt  <= 80;
            end
        end else if (!m_idle) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_idle <= 1'b1;
        end
        if (xst_we)  n_we  <= n_we + 1;
        if (xst_wer) n_wer <= n_wer + 1;
        if (xst_oe)  n_oe  <= n_oe + 1;
        if (xst_oer) n_oer <= n_oer + 1;
        if (rx_valid && rx_ready) rx_log.push_back(rx_dat);
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [63:0] d, input logic [5:0] b, input logic r, output logic acc);
        @(negedge clk);
        tx_dat   = d;
        tx_bits  = b;
        tx_rev   = r;
        tx_valid = 1'b1;
        acc      = tx_ready;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_cap(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (xst_oe || xst_oer) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    logic        acc, ok;
    int          s_we, s_wer, s_oe, s_oer, ls, r0, n_acc;
    logic [63:0] w4 [4];

    initial begin
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_dat   = 64'd0;
        tx_bits  = 6'd0;
        tx_rev   = 1'b0;
        rx_ready = 1'b0;

        // 1: reset state
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        check("rst_tx_level", 64'(tx_level), 64'd0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_strobes", 64'({xst_we, xst_wer, xst_oe, xst_oer}), 64'd0);
        check("rst_xst_dat", xst_dat_o, 64'd0);
        check("rst_rx_dat", rx_dat, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2: direct transfer
        s_we = n_we; s_wer = n_wer; s_oe = n_oe; s_oer = n_oer;
        push(64'hA5, 6'd8, 1'b0, acc);
        check("t2_accept", 64'(acc), 64'd1);
        @(negedge clk);
        check("t2_we_early", 64'(xst_we), 64'd0);
        @(negedge clk);
        check("t2_we", 64'(xst_we), 64'd1);
        check("t2_wer", 64'(xst_wer), 64'd0);
        check("t2_load_dat", xst_dat_o, 64'hA5);
        check("t2_load_bits", 64'(xst_bits_o), 64'd8);
        @(negedge clk);
        check("t2_we_width", 64'(xst_we), 64'd0);
        wait_cap(300, ok);
        check("t2_cap_seen", 64'(ok), 64'd1);
        check("t2_oe", 64'(xst_oe), 64'd1);
        check("t2_oer", 64'(xst_oer), 64'd0);
        check("t2_rx_not_yet", 64'(rx_valid), 64'd0);
        @(negedge clk);
        check("t2_rx_valid", 64'(rx_valid), 64'd1);
        check("t2_rx_dat", rx_dat, 64'hFFFF_FFFF_FFFF_FF5A);
        check("t2_rx_bits", 64'(rx_bits), 64'd8);
        check("t2_oe_width", 64'(xst_oe), 64'd0);
        check("t2_n_we", 64'(n_we - s_we), 64'd1);
        check("t2_n_oe", 64'(n_oe - s_oe), 64'd1);
        check("t2_n_rev", 64'((n_wer - s_wer) + (n_oer - s_oer)), 64'd0);
        pop_one();
        @(negedge clk);
        check("t2_rx_popped", 64'(rx_valid), 64'd0);

        // 3: reversed transfer
        s_we = n_we; s_wer = n_wer; s_oe = n_oe; s_oer = n_oer;
        push(64'hA5, 6'd8, 1'b1, acc);
        @(negedge clk);
        @(negedge clk);
        check("t3_wer", 64'(xst_wer), 64'd1);
        check("t3_we", 64'(xst_we), 64'd0);
        wait_cap(300, ok);
        check("t3_cap_seen", 64'(ok), 64'd1);
        check("t3_oer", 64'(xst_oer), 64'd1);
        check("t3_oe", 64'(xst_oe), 64'd0);
        @(negedge clk);
        check("t3_rx_dat", rx_dat, 64'hFFFF_FFFF_FFFF_FF5A);
        check("t3_n_direct", 64'((n_we - s_we) + (n_oe - s_oe)), 64'd0);
        check("t3_n_wer", 64'(n_wer - s_wer), 64'd1);
        check("t3_n_oer", 64'(n_oer - s_oer), 64'd1);
        pop_one();

        // 4: TX full while xst busy, then FIFO-order drain
        w4[0] = 64'h11; w4[1] = 64'h22; w4[2] = 64'h33; w4[3] = 64'h44;
        hold_busy = 1'b1;
        s_we = n_we; s_wer = n_wer;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            push(w4[i], 6'd4, 1'b0, acc);
            if (acc) n_acc++;
        end
        push(64'h55, 6'd4, 1'b0, acc);
        if (acc) n_acc++;
        @(negedge clk);
        check("t4_accepted", 64'(n_acc), 64'd4);
        check("t4_tx_ready", 64'(tx_ready), 64'd0);
        check("t4_tx_level", 64'(tx_level), 64'd4);
        repeat (10) @(negedge clk);
        check("t4_no_load", 64'((n_we - s_we) + (n_wer - s_wer)), 64'd0);
        ls = load_log.size();
        r0 = rx_log.size();
        rx_ready  = 1'b1;
        hold_busy = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (rx_log.size() >= r0 + 4) begin
                ok = 1'b1;
                break;
            end
        end
        rx_ready = 1'b0;
        check("t4_drained", 64'(ok), 64'd1);
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t4_load_%0d", i), load_log[ls + i], w4[i]);
                check($sformatf("t4_rx_%0d", i), rx_log[r0 + i], ~w4[i]);
            end
        end

        // 5: RX full blocks further loads; bits=0 returns the loaded word
        s_we = n_we;
        for (int i = 0; i < 5; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) push(64'h61 + 64'(i), 6'd0, 1'b0, acc);
        end
        repeat (40) @(negedge clk);
        check("t5_loads_capped", 64'(n_we - s_we), 64'd4);
        check("t5_rx_valid", 64'(rx_valid), 64'd1);
        check("t5_rx_head", rx_dat, 64'h61);
        check("t5_rx_bits0", 64'(rx_bits), 64'd0);
        check("t5_tx_level", 64'(tx_level), 64'd1);
        repeat (20) @(negedge clk);
        check("t5_still_capped", 64'(n_we - s_we), 64'd4);
        r0 = rx_log.size();
        pop_one();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (n_we - s_we == 5) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_fifth_load", 64'(ok), 64'd1);
        rx_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_log.size() >= r0 + 5) begin
                ok = 1'b1;
                break;
            end
        end
        rx_ready = 1'b0;
        check("t5_drained", 64'(ok), 64'd1);
        if (ok) begin
            for (int i = 0; i < 5; i++)
                check($sformatf("t5_rx_%0d", i), rx_log[r0 + i], 64'h61 + 64'(i));
        end

        // 6: reset during BUSY
        s_we = n_we; s_oe = n_oe; s_oer = n_oer;
        push(64'hA5, 6'd8, 1'b0, acc);
        push(64'hB6, 6'd8, 1'b0, acc);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (xst_we) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_loaded", 64'(ok), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_tx_level", 64'(tx_level), 64'd0);
        check("t6_tx_ready", 64'(tx_ready), 64'd1);
        check("t6_rx_valid", 64'(rx_valid), 64'd0);
        check("t6_strobes", 64'({xst_we, xst_wer, xst_oe, xst_oer}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(negedge clk);
        check("t6_no_capture", 64'((n_oe - s_oe) + (n_oer - s_oer)), 64'd0);
        check("t6_one_load", 64'(n_we - s_we), 64'd1);
        check("t6_rx_empty", 64'(rx_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
